// File: rtl/movavg_pkg.sv
// Shared types and arithmetic for the moving-average output stage.
// Both lanes travel together as one pair_t entry through the result FIFO.
package movavg_pkg;

    typedef logic [63:0] sample_t;

    typedef struct packed {
        sample_t a;
        sample_t b;
    } pair_t;

    localparam int DEFAULT_WARMUP = 2;

    // Divide a 4-sample sum by 4 with round-half-up. The +2 needs the 65th bit,
    // otherwise sums near 2^64 would wrap before the shift.
    function automatic sample_t round_div4(input sample_t sum);
        logic [64:0] sum_ext;
        sum_ext = {1'b0, sum} + 65'd2;
        return sample_t'(sum_ext >> 2);
    endfunction

endpackage

// File: rtl/pair_fifo.sv
// Small synchronous FIFO of result pairs with a registered read port.
// rdata always holds the head entry, so it is stable while nothing is popped.
module pair_fifo
    import movavg_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  push,
    input  logic  pop,
    input  pair_t wdata,
    output pair_t rdata,
    output logic  full,
    output logic  empty
);

    localparam int AW = $clog2(DEPTH);

    pair_t          r_mem [DEPTH];
    pair_t          r_rdata;
    logic [AW:0]    r_wr_ptr;
    logic [AW:0]    r_rd_ptr;

    logic           w_do_push;
    logic           w_do_pop;
    logic [AW:0]    w_wr_next;
    logic [AW:0]    w_rd_next;
    logic           w_next_empty;

    // Equal pointers mean empty; equal index with opposite wrap bits means full.
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_do_pop     = pop && !empty;
    assign w_do_push    = push && (!full || w_do_pop);
    assign w_wr_next    = w_do_push ? r_wr_ptr + (AW+1)'(1) : r_wr_ptr;
    assign w_rd_next    = w_do_pop  ? r_rd_ptr + (AW+1)'(1) : r_rd_ptr;
    assign w_next_empty = (w_wr_next == w_rd_next);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_wr_ptr <= w_wr_next;
            r_rd_ptr <= w_rd_next;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers alone
    // define which entries are valid, and an unreset array maps onto RAM.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= wdata;
        end
    end

    // Load the next head; forward wdata when the entry being written becomes the head.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
        end else if ((w_do_push || w_do_pop) && !w_next_empty) begin
            if (w_do_push && (r_wr_ptr[AW-1:0] == w_rd_next[AW-1:0])) begin
                r_rdata <= wdata;
            end else begin
                r_rdata <= r_mem[w_rd_next[AW-1:0]];
            end
        end
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/movavg_post.sv
// Output stage of the two-lane moving-average adder: rounds each sum / 4, drops
// warm-up pairs, buffers results and reports overflow since the adder cannot stall.
module movavg_post
    import movavg_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int WARMUP = DEFAULT_WARMUP,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sum_valid,
    input  logic [63:0]      sumA,
    input  logic [63:0]      sumB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      avgA,
    output logic [63:0]      avgB,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_count,
    input  logic             clear_ovf
);

    localparam int WU_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

    logic [WU_W-1:0]  r_warm;
    logic             r_overflow;
    logic [CNT_W-1:0] r_drop_count;

    logic             w_warm_done;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    pair_t            w_wdata;
    pair_t            w_rdata;

    assign w_warm_done = (r_warm == '0);
    assign w_pop       = !w_empty && out_ready;
    assign w_wdata     = '{a: round_div4(sumA), b: round_div4(sumB)};

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the block can leave a value held and infer a latch.
        w_push = 1'b0;
        w_drop = 1'b0;
        if (sum_valid && w_warm_done) begin
            if (!w_full || w_pop) begin
                w_push = 1'b1;
            end else begin
                w_drop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_warm <= WU_W'(WARMUP);
        end else if (sum_valid && !w_warm_done) begin
            r_warm <= r_warm - WU_W'(1);
        end
    end

    // Clear beats a concurrent drop; that drop is intentionally not counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (clear_ovf) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_count != '1) begin
                r_drop_count <= r_drop_count + CNT_W'(1);
            end
        end
    end

    pair_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (w_wdata),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty)
    );

    assign out_valid  = !w_empty;
    assign avgA       = w_rdata.a;
    assign avgB       = w_rdata.b;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_movavg_post.sv
// Scoreboard bench for movavg_post: stimulus pushes hand-computed averages into a
// queue, an independent monitor pops and compares on every accepted output.
module tb_movavg_post;
    import movavg_pkg::*;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             sum_valid = 1'b0;
    logic [63:0]      sumA = '0;
    logic [63:0]      sumB = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [63:0]      avgA;
    logic [63:0]      avgB;
    logic             overflow;
    logic [CNT_W-1:0] drop_count;
    logic             clear_ovf = 1'b0;

    int    n_cmp = 0;
    int    n_err = 0;
    pair_t exp_q [$];

    movavg_post #(
        .DEPTH  (4),
        .WARMUP (2),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sum_valid  (sum_valid),
        .sumA       (sumA),
        .sumB       (sumB),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .avgA       (avgA),
        .avgB       (avgB),
        .overflow   (overflow),
        .drop_count (drop_count),
        .clear_ovf  (clear_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, got, exp);
        end
    endtask

    // One input pair for one cycle; keep=1 means the bench expects it to reach the output.
    task automatic send(input logic [63:0] sa, input logic [63:0] sb,
                        input logic [63:0] ea, input logic [63:0] eb, input bit keep);
        pair_t p;
        if (keep) begin
            p.a = ea;
            p.b = eb;
            exp_q.push_back(p);
        end
        sum_valid = 1'b1;
        sumA      = sa;
        sumB      = sb;
        @(posedge clk);
        #1;
        sum_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int cycles;
        out_ready = 1'b1;
        cycles = 0;
        while (out_valid && cycles < 50) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check(name, {63'd0, out_valid}, 64'd0);
    endtask

    // Monitor: every accepted output is compared against the scoreboard head.
    initial begin
        pair_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: got avgA=0x%h avgB=0x%h, expected no output", avgA, avgB);
                end else begin
                    e = exp_q.pop_front();
                    check("avgA", avgA, e.a);
                    check("avgB", avgB, e.b);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #12;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_avgA", avgA, 64'd0);
        check("rst_avgB", avgB, 64'd0);
        check("rst_overflow", {63'd0, overflow}, 64'd0);
        check("rst_drop_count", 64'(drop_count), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 1. Warm-up discard: first two pairs vanish, third gives 5/6 a cycle later
        out_ready = 1'b1;
        send(64'd4, 64'd8, 64'd0, 64'd0, 1'b0);
        check("warm1_out_valid", {63'd0, out_valid}, 64'd0);
        send(64'd12, 64'd16, 64'd0, 64'd0, 1'b0);
        check("warm2_out_valid", {63'd0, out_valid}, 64'd0);
        send(64'd20, 64'd24, 64'd5, 64'd6, 1'b1);
        check("latency_out_valid", {63'd0, out_valid}, 64'd1);
        drain("drain_t1");

        // 2. Rounding boundaries
        send(64'd1, 64'd1, 64'd0, 64'd0, 1'b1);
        send(64'd2, 64'd2, 64'd1, 64'd1, 1'b1);
        send(64'd5, 64'd5, 64'd1, 64'd1, 1'b1);
        send(64'd6, 64'd6, 64'd2, 64'd2, 1'b1);
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
             64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b1);
        drain("drain_t2");

        // 3. Back-pressure fill, then one dropped pair
        out_ready = 1'b0;
        send(64'd100, 64'd200, 64'd25, 64'd50, 1'b1);
        send(64'd104, 64'd204, 64'd26, 64'd51, 1'b1);
        send(64'd108, 64'd208, 64'd27, 64'd52, 1'b1);
        send(64'd112, 64'd212, 64'd28, 64'd53, 1'b1);
        check("full_out_valid", {63'd0, out_valid}, 64'd1);
        check("full_overflow", {63'd0, overflow}, 64'd0);
        check("hold_avgA", avgA, 64'd25);
        check("hold_avgB", avgB, 64'd50);
        send(64'd116, 64'd216, 64'd0, 64'd0, 1'b0);
        check("drop_overflow", {63'd0, overflow}, 64'd1);
        check("drop_count_1", 64'(drop_count), 64'd1);
        check("hold_after_drop_avgA", avgA, 64'd25);
        drain("drain_t3");

        clear_ovf = 1'b1;
        @(posedge clk);
        #1;
        clear_ovf = 1'b0;
        check("clear_overflow", {63'd0, overflow}, 64'd0);
        check("clear_drop_count", 64'(drop_count), 64'd0);

        // 4. Full FIFO with simultaneous push and pop for 10 cycles
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++)
            send(64'(4 * k + 1000), 64'(4 * k + 2), 64'(k + 250), 64'(k + 1), 1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++)
            send(64'(4 * i + 300), 64'(4 * i + 3), 64'(i + 75), 64'(i + 1), 1'b1);
        check("pp_overflow", {63'd0, overflow}, 64'd0);
        check("pp_drop_count", 64'(drop_count), 64'd0);
        drain("drain_t4");

        // 5. Counter saturation at 15, then clear racing a drop
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++)
            send(64'(4 * k + 40), 64'(4 * k + 80), 64'(k + 10), 64'(k + 20), 1'b1);
        for (int k = 0; k < 20; k++)
            send(64'd999, 64'd999, 64'd0, 64'd0, 1'b0);
        check("sat_drop_count", 64'(drop_count), 64'd15);
        check("sat_overflow", {63'd0, overflow}, 64'd1);
        clear_ovf = 1'b1;
        send(64'd999, 64'd999, 64'd0, 64'd0, 1'b0);
        clear_ovf = 1'b0;
        check("race_overflow", {63'd0, overflow}, 64'd0);
        check("race_drop_count", 64'(drop_count), 64'd0);
        drain("drain_t5");

        // 6. Async reset with 3 pairs buffered; warm-up re-arms
        out_ready = 1'b0;
        send(64'd500, 64'd600, 64'd0, 64'd0, 1'b0);
        send(64'd504, 64'd604, 64'd0, 64'd0, 1'b0);
        send(64'd508, 64'd608, 64'd0, 64'd0, 1'b0);
        check("pre_rst_out_valid", {63'd0, out_valid}, 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("async_rst_avgA", avgA, 64'd0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(64'd20, 64'd24, 64'd0, 64'd0, 1'b0);
        send(64'd28, 64'd32, 64'd0, 64'd0, 1'b0);
        check("rewarm_out_valid", {63'd0, out_valid}, 64'd0);
        send(64'd40, 64'd44, 64'd10, 64'd11, 1'b1);
        check("rewarm_latency", {63'd0, out_valid}, 64'd1);
        drain("drain_t6");

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/movavg_post.md
Name: movavg_post

Overview:
- Output stage directly downstream of the two-lane 64-bit moving-average adder.
- Takes the two 4-sample sums produced every cycle and divides each by 4 with round-half-up.
- Discards the warm-up pairs computed from reset-zero taps.
- Buffers results in a small FIFO and presents them to the consumer over a valid/ready handshake. The adder cannot stall, so overflow is detected, counted and flagged rather than back-pressured.

Parameters:
- DEPTH, 4, FIFO depth in result pairs; power of two, at least 2.
- WARMUP, 2, number of accepted input pairs discarded after reset.
- CNT_W, 16, width of the saturating drop counter.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- sum_valid  input  1  sumA/sumB carry a new pair this cycle
- sumA  input  64  lane A 4-sample sum, modulo 2^64
- sumB  input  64  lane B 4-sample sum, modulo 2^64
- out_valid  output  1  avgA/avgB hold a buffered result
- out_ready  input  1  consumer accepts the result this cycle
- avgA  output  64  lane A average
- avgB  output  64  lane B average
- overflow  output  1  sticky flag: a pair was dropped
- drop_count  output  CNT_W  saturating count of dropped pairs
- clear_ovf  input  1  synchronous clear of overflow and drop_count

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, avgA=avgB=0, overflow=0, drop_count=0.
  - FIFO empty; warm-up counter = WARMUP.
  - Reset mid-stream discards all FIFO contents and re-arms warm-up.
- Arithmetic, per lane:
  - avg = (sum + 2) >> 2, computed in 65 bits.
  - Result zero-extended to 64 bits; no saturation needed (maximum 2^62).
  - Input wrap in the adder is not detected here.
- Warm-up:
  - While the warm-up counter is nonzero, each sum_valid decrements it and the pair is discarded.
  - Warm-up discards are not drops and never touch overflow or drop_count.
- Push: sum_valid=1, warm-up complete and (FIFO not full, or pop in the same cycle) writes the rounded pair.
- Pop: out_valid && out_ready.
- Simultaneous push+pop:
  - When full, both happen; occupancy is unchanged.
  - When empty, only the push happens. No bypass: out_valid rises the next cycle.
- Latency: sum_valid at cycle N on an empty FIFO gives out_valid=1 with data at cycle N+1.
- Output data is registered and stable while out_valid=1 && out_ready=0.
- Drop:
  - Occurs when sum_valid=1, warm-up is complete, the FIFO is full and there is no pop.
  - The pair is discarded; overflow is set; drop_count increments, saturating at 2^CNT_W-1.
- clear_ovf:
  - Zeroes overflow and drop_count.
  - If a drop happens in the same cycle, clear wins and the counter reads 0. The drop is lost by design.
- Ordering: strict FIFO; lanes A and B always travel as one entry.
- Pointers: log2(DEPTH) bits plus a wrap bit; full/empty are decided from the wrap bit.

Decomposition:
- Package movavg_pkg holds:
  - typedef sample_t (logic [63:0]);
  - typedef pair_t (struct: sample_t a, sample_t b);
  - function round_div4 (65-bit add and shift);
  - constant DEFAULT_WARMUP = 2.
- One sub-module: pair_fifo.
  - Parameterized DEPTH, data type pair_t.
  - Ports: push, pop, wdata, rdata, full, empty.
  - Registered rdata and async reset.
- Top level holds the rounding, warm-up counter, drop/overflow logic and handshake glue.

Test Plan:
1. Warm-up discard: reset, then sum_valid with sums 4/8, 12/16, 20/24 on consecutive cycles, out_ready=1.
   - First output pair is 5/6, one cycle after the third input.
   - out_valid is never asserted before that.
2. Rounding boundaries: after warm-up, sumA = 1, 2, 5, 6, 0xFFFF_FFFF_FFFF_FFFF (sumB mirrors).
   - avgA = 0, 1, 1, 2, 0x4000_0000_0000_0000.
3. Back-pressure fill: out_ready=0, 4 valid pairs after warm-up.
   - FIFO full, overflow stays 0, avgA holds the first result stable.
   - A fifth pair sets overflow=1, drop_count=1.
   - Draining yields exactly the 4 stored pairs in order.
4. Full with simultaneous pop: FIFO full, out_ready=1 and sum_valid=1 for 10 cycles.
   - No drops; outputs stay in strict order.
5. Counter saturation and clear: CNT_W=4, 20 drops.
   - drop_count=15.
   - clear_ovf with a concurrent drop gives overflow=0 and drop_count=0 the next cycle.
6. Async reset mid-operation: FIFO holding 3 pairs, assert reset off-edge.
   - out_valid=0 immediately.
   - After release, the next 2 valid pairs are discarded as warm-up.
